vec_mem_sequencer: RTL and testbench
====================================

Name: vec_mem_sequencer

Overview:
- Controller in front of the 512-word single-port data memory of the 512-bit vector processor.
- Arbitrates between four vector-register load requesters and one vector store requester.
- Sequences each granted 512-bit transfer (32 lanes x 16 bit) as 32 single-word memory accesses, one lane per cycle.
- Assembles load results into a full vector, and rejects out-of-range base indices.

Parameters:
- ADDR_W, 9, memory word address width (512 words).
- MEM_W, 32, memory word width.
- LANES, 32, lanes per vector.
- LANE_W, 16, lane width (signed).
- NREQ, 4, number of load requesters.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ld_req  in  NREQ  per-requester load request, level, held until matching ld_done.
- ld_idx  in  NREQ*ADDR_W  per-requester base word index; slice r is bits [r*ADDR_W +: ADDR_W].
- st_req  in  1  store request, level, held until st_done or err.
- st_idx  in  ADDR_W  store base word index.
- st_data  in  LANES*LANE_W  store vector; lane i is bits [i*LANE_W +: LANE_W].
- ld_grant  out  NREQ  one-hot owner of the current load transaction.
- ld_done  out  NREQ  one-cycle pulse to the owner when ld_data is valid.
- ld_data  out  LANES*LANE_W  assembled load vector.
- st_done  out  1  one-cycle pulse when the store completes.
- err  out  1  one-cycle pulse when a request is rejected for range.
- busy  out  1  high in every state except IDLE.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  MEM_W  memory write data.
- mem_rdata  in  MEM_W  memory read data, valid one cycle after address presentation.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, round-robin pointer at requester 0. Reset is asynchronous.
- Reset mid-transaction: aborts immediately and no done pulse is produced. Partial memory writes are not rolled back.
- FSM states: IDLE, LOAD, DRAIN, STORE, DONE.
- IDLE arbitration:
  - st_req has priority over any ld_req.
  - Loads are granted round-robin, searching from the pointer; the pointer moves to grant+1 mod NREQ after each accepted load.
  - Base index and st_data are latched on acceptance; later changes to inputs are ignored until the next acceptance.
- Range check: base + LANES - 1 > 2^ADDR_W - 1 means reject.
  - Rejected request produces an err pulse for one cycle and the FSM stays in IDLE.
  - For a rejected load, ld_grant pulses with err for that cycle so the requester can identify itself and drop ld_req.
  - For a rejected store, the pointer is unchanged.
  - Boundary: base 480 accepted (last word 511); base 481 rejected.
- LOAD:
  - ld_grant is held for the whole transaction.
  - LANES cycles with mem_addr = base+k for k = 0..LANES-1, mem_we = 0.
  - Lane k-1 is captured from mem_rdata[LANE_W-1:0] in cycle k.
  - Then DRAIN for one cycle, capturing lane LANES-1.
  - Then DONE: ld_done[owner] = 1 for one cycle, ld_grant cleared.
  - Load latency is LANES+2 cycles from acceptance edge to the ld_done cycle.
  - ld_data holds until the next load's DONE and is not updated lane-by-lane visibly. Assemble into a shadow register and copy in DONE.
- STORE:
  - LANES cycles with mem_we = 1, mem_addr = base+k.
  - mem_wdata = lane k sign-extended to MEM_W.
  - Then DONE with st_done = 1 for one cycle. Store latency is LANES+1 cycles.
- DONE always returns to IDLE. Minimum one IDLE cycle between transactions, so arbitration sees updated requests.
- A requester dropping its req mid-transaction has no effect; the transaction completes and still pulses done.
- mem_we is 0 in all states except STORE. mem_addr is 0 in IDLE, DRAIN and DONE.

Optional Feature:
- Macro: VMEM_PERF_CNT_EN.
- When defined, adds three outputs, each 16 bit, saturating at 16'hFFFF, reset to 0:
  - perf_ld_cnt: +1 per ld_done.
  - perf_st_cnt: +1 per st_done.
  - perf_wait_cnt: +1 per cycle any request is pending but not being served (any ld_req or st_req high while busy, excluding the owner's own request).
- When not defined, these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Load from base 0:
  - Stimulus: memory word i = 32'h0000_1000+i; ld_req = 4'b0001, ld_idx[0] = 0.
  - Required: ld_grant = 0001 for 34 cycles; ld_done[0] pulses on cycle 34 after acceptance; lane i of ld_data = 16'h1000+i.
- Store then read back:
  - Stimulus: st_idx = 100; lane i = -i.
  - Required: 32 consecutive writes at addresses 100..131 with mem_wdata = 32'hFFFF_FFFF..32'hFFFF_FFE1 (lane 0 = 0); st_done pulses; a later load from 100 returns identical lanes.
- Contention:
  - Stimulus: ld_req = 4'b1111 and st_req = 1 raised together.
  - Required: service order is store, then ld0, ld1, ld2, ld3; exactly one done pulse each; no overlap of grants.
- Range boundary:
  - Stimulus: ld_idx = 480.
  - Required: completes normally, last mem_addr = 511.
  - Stimulus: ld_idx = 481.
  - Required: err + ld_grant pulse one cycle, no memory access, busy stays 0.
- Reset mid-store:
  - Stimulus: rst_n low at lane 10.
  - Required: mem_we drops to 0 asynchronously; no st_done; state IDLE; outputs 0.
- With VMEM_PERF_CNT_EN, after the contention test:
  - Required: perf_ld_cnt = 4, perf_st_cnt = 1, perf_wait_cnt > 0.

Source files
------------

// File: rtl/vec_mem_sequencer_if.sv
// Request/response and memory-side signals of the vector memory sequencer.
// master = requesters plus memory model, slave = the sequencer.
interface vec_mem_sequencer_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned MEM_W  = 32,
  parameter int unsigned LANES  = 32,
  parameter int unsigned LANE_W = 16,
  parameter int unsigned NREQ   = 4
);
  logic [NREQ-1:0]          ld_req;
  logic [NREQ*ADDR_W-1:0]   ld_idx;
  logic                     st_req;
  logic [ADDR_W-1:0]        st_idx;
  logic [LANES*LANE_W-1:0]  st_data;
  logic [NREQ-1:0]          ld_grant;
  logic [NREQ-1:0]          ld_done;
  logic [LANES*LANE_W-1:0]  ld_data;
  logic                     st_done;
  logic                     err;
  logic                     busy;
  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_we;
  logic [MEM_W-1:0]         mem_wdata;
  logic [MEM_W-1:0]         mem_rdata;

  modport master (
    output ld_req, ld_idx, st_req, st_idx, st_data, mem_rdata,
    input  ld_grant, ld_done, ld_data, st_done, err, busy, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  ld_req, ld_idx, st_req, st_idx, st_data, mem_rdata,
    output ld_grant, ld_done, ld_data, st_done, err, busy, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vec_mem_sequencer.sv
// Serialises vector loads/stores onto a single-port word memory, one lane per cycle.
// Define VMEM_PERF_CNT_EN to add saturating load/store/wait performance counters.
module vec_mem_sequencer #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned MEM_W  = 32,
  parameter int unsigned LANES  = 32,
  parameter int unsigned LANE_W = 16,
  parameter int unsigned NREQ   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  vec_mem_sequencer_if.slave  bus
`ifdef VMEM_PERF_CNT_EN
  ,
  output logic [15:0]         perf_ld_cnt,
  output logic [15:0]         perf_st_cnt,
  output logic [15:0]         perf_wait_cnt
`endif
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = $clog2(LANES);
  localparam int unsigned VEC_W = LANES * LANE_W;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_STORE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, nxt_k;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d, pick;
  logic [ADDR_W-1:0]   pick_idx;
  logic [VEC_W-1:0]    shadow_q, shadow_d, stbuf_q, stbuf_d;
  logic [NREQ-1:0]     ld_grant_q, ld_grant_d, ld_done_q, ld_done_d;
  logic [VEC_W-1:0]    ld_data_q, ld_data_d;
  logic                st_done_q, st_done_d, err_q, err_d, busy_q, busy_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [MEM_W-1:0]    mem_wdata_q, mem_wdata_d;

  function automatic logic in_range(input logic [ADDR_W-1:0] b);
    return (32'(b) + 32'(LANES) - 32'd1) <= ((32'd1 << ADDR_W) - 32'd1);
  endfunction

  function automatic logic [MEM_W-1:0] sext(input logic [LANE_W-1:0] v);
    return MEM_W'($signed(v));
  endfunction

  // Round-robin search starting at the pointer.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NREQ-1:0] req,
                                               input logic [PTR_W-1:0] start);
    logic [PTR_W-1:0] sel;
    logic             found;
    int unsigned      c;
    sel   = start;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      c = (32'(start) + i) % NREQ;
      if (!found && req[PTR_W'(c)]) begin
        sel   = PTR_W'(c);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    ptr_d       = ptr_q;
    shadow_d    = shadow_q;
    stbuf_d     = stbuf_q;
    ld_grant_d  = ld_grant_q;
    ld_done_d   = '0;
    ld_data_d   = ld_data_q;
    st_done_d   = 1'b0;
    err_d       = 1'b0;
    mem_addr_d  = '0;
    mem_we_d    = 1'b0;
    mem_wdata_d = '0;
    nxt_k       = cnt_q + CNT_W'(1);
    pick        = rr_pick(bus.ld_req, ptr_q);
    pick_idx    = bus.ld_idx[32'(pick)*ADDR_W +: ADDR_W];

    unique case (state_q)
      S_IDLE: begin
        ld_grant_d = '0;
        // Skip one cycle after a reject so the requester can drop its request.
        if (!err_q) begin
          if (bus.st_req) begin
            if (in_range(bus.st_idx)) begin
              state_d     = S_STORE;
              base_d      = bus.st_idx;
              stbuf_d     = bus.st_data;
              cnt_d       = '0;
              mem_we_d    = 1'b1;
              mem_addr_d  = bus.st_idx;
              mem_wdata_d = sext(bus.st_data[LANE_W-1:0]);
            end else begin
              err_d = 1'b1;
            end
          end else if (|bus.ld_req) begin
            ld_grant_d = NREQ'(1) << pick;
            if (in_range(pick_idx)) begin
              state_d    = S_LOAD;
              base_d     = pick_idx;
              cnt_d      = '0;
              mem_addr_d = pick_idx;
              ptr_d      = (pick == PTR_W'(NREQ-1)) ? '0 : pick + PTR_W'(1);
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      S_LOAD: begin
        // Read data trails the address by one cycle, so lane k-1 lands in cycle k.
        if (cnt_q != '0)
          shadow_d[(32'(cnt_q) - 32'd1)*LANE_W +: LANE_W] = bus.mem_rdata[LANE_W-1:0];
        if (cnt_q == CNT_W'(LANES-1)) begin
          state_d = S_DRAIN;
        end else begin
          cnt_d      = nxt_k;
          mem_addr_d = base_q + ADDR_W'(nxt_k);
        end
      end
      S_DRAIN: begin
        ld_data_d = {bus.mem_rdata[LANE_W-1:0], shadow_q[VEC_W-LANE_W-1:0]};
        ld_done_d = ld_grant_q;
        state_d   = S_DONE;
      end
      S_STORE: begin
        if (cnt_q == CNT_W'(LANES-1)) begin
          state_d   = S_DONE;
          st_done_d = 1'b1;
        end else begin
          cnt_d       = nxt_k;
          mem_we_d    = 1'b1;
          mem_addr_d  = base_q + ADDR_W'(nxt_k);
          mem_wdata_d = sext(stbuf_q[32'(nxt_k)*LANE_W +: LANE_W]);
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        ld_grant_d = '0;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      ptr_q       <= '0;
      shadow_q    <= '0;
      stbuf_q     <= '0;
      ld_grant_q  <= '0;
      ld_done_q   <= '0;
      ld_data_q   <= '0;
      st_done_q   <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      ptr_q       <= ptr_d;
      shadow_q    <= shadow_d;
      stbuf_q     <= stbuf_d;
      ld_grant_q  <= ld_grant_d;
      ld_done_q   <= ld_done_d;
      ld_data_q   <= ld_data_d;
      st_done_q   <= st_done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.ld_grant  = ld_grant_q;
  assign bus.ld_done   = ld_done_q;
  assign bus.ld_data   = ld_data_q;
  assign bus.st_done   = st_done_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;

`ifdef VMEM_PERF_CNT_EN
  logic own_st_c, wait_c;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // The store owner's st_req stays high through DONE and must not count as waiting.
  always_comb begin
    own_st_c = (state_q == S_STORE) || st_done_q;
    wait_c   = busy_q && ((bus.st_req && !own_st_c) || |(bus.ld_req & ~ld_grant_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ld_cnt   <= '0;
      perf_st_cnt   <= '0;
      perf_wait_cnt <= '0;
    end else begin
      if (|ld_done_q) perf_ld_cnt   <= sat_inc(perf_ld_cnt);
      if (st_done_q)  perf_st_cnt   <= sat_inc(perf_st_cnt);
      if (wait_c)     perf_wait_cnt <= sat_inc(perf_wait_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer with a one-cycle-latency memory model.
module tb_vec_mem_sequencer;

  logic clk;
  logic rst_n;
  logic mem_init;
  int   checks;
  int   failures;
  logic [31:0] mem [512];

  vec_mem_sequencer_if bus ();

`ifdef VMEM_PERF_CNT_EN
  logic [15:0] perf_ld_cnt, perf_st_cnt, perf_wait_cnt;
`endif

  vec_mem_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef VMEM_PERF_CNT_EN
    ,
    .perf_ld_cnt   (perf_ld_cnt),
    .perf_st_cnt   (perf_st_cnt),
    .perf_wait_cnt (perf_wait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'h0000_1000 + 32'(i);
      bus.mem_rdata <= '0;
    end else begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input int r, input int idx, input logic [511:0] exp);
    int   lat;
    logic ok_grant, ok_addr;
    logic [8:0] last_addr;
    lat = 0; ok_grant = 1'b1; ok_addr = 1'b1; last_addr = '0;
    bus.ld_idx[r*9 +: 9] = 9'(idx);
    bus.ld_req[r] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.ld_grant !== 4'(1 << r)) ok_grant = 1'b0;
      if (c <= 32 && (bus.mem_addr !== 9'(idx + c - 1) || bus.mem_we !== 1'b0)) ok_addr = 1'b0;
      if (c == 32) last_addr = bus.mem_addr;
      if (bus.ld_done[r]) begin
        lat = c;
        break;
      end
    end
    bus.ld_req[r] = 1'b0;
    check("ld_latency", 512'(lat), 512'(34));
    check("ld_grant_held", 512'(ok_grant), 512'(1));
    check("ld_addr_seq", 512'(ok_addr), 512'(1));
    check("ld_last_addr", 512'(last_addr), 512'(idx + 31));
    check("ld_data", bus.ld_data, exp);
    @(negedge clk);
    check("ld_after_idle", 512'({bus.busy, bus.ld_grant, bus.ld_done}), 512'(0));
  endtask

  task automatic do_store(input int idx, input logic [511:0] data,
                          output logic [31:0] wd1, output logic [31:0] wd31);
    int   lat;
    logic ok;
    logic [15:0] lane;
    lat = 0; ok = 1'b1; wd1 = '0; wd31 = '0;
    bus.st_idx  = 9'(idx);
    bus.st_data = data;
    bus.st_req  = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c <= 32) begin
        lane = data[(c-1)*16 +: 16];
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 9'(idx + c - 1) ||
            bus.mem_wdata !== {{16{lane[15]}}, lane}) ok = 1'b0;
      end
      if (c == 2)  wd1  = bus.mem_wdata;
      if (c == 32) wd31 = bus.mem_wdata;
      if (bus.st_done) begin
        lat = c;
        break;
      end
    end
    bus.st_req = 1'b0;
    check("st_latency", 512'(lat), 512'(33));
    check("st_write_seq", 512'(ok), 512'(1));
    @(negedge clk);
    check("st_after_idle", 512'({bus.busy, bus.mem_we, bus.st_done}), 512'(0));
  endtask

  initial begin
    logic [511:0] vec;
    logic [31:0]  wd1, wd31;
    logic         found, saw_done, overlap, err_seen;
    int           got [5];
    int           n;

    checks = 0; failures = 0;
    rst_n = 1'b0; mem_init = 1'b1;
    bus.ld_req = '0; bus.ld_idx = '0; bus.st_req = 1'b0; bus.st_idx = '0; bus.st_data = '0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_ctrl", 512'({bus.ld_grant, bus.ld_done, bus.st_done, bus.err, bus.busy, bus.mem_we}), 512'(0));
    check("rst_mem", 512'({bus.mem_addr, bus.mem_wdata}), 512'(0));
    check("rst_ld_data", bus.ld_data, 512'(0));
`ifdef VMEM_PERF_CNT_EN
    check("rst_perf", 512'({perf_ld_cnt, perf_st_cnt, perf_wait_cnt}), 512'(0));
`endif
    rst_n = 1'b1; mem_init = 1'b0;
    @(negedge clk);

    // Load requester 0 from base 0: lanes 16'h1000+i
    for (int i = 0; i < 32; i++) vec[i*16 +: 16] = 16'h1000 + 16'(i);
    do_load(0, 0, vec);

    // Store base 100 with lane i = -i
    for (int i = 0; i < 32; i++) vec[i*16 +: 16] = 16'(0) - 16'(i);
    do_store(100, vec, wd1, wd31);
    check("st_wdata_lane1", 512'(wd1), 512'(32'hFFFF_FFFF));
    check("st_wdata_lane31", 512'(wd31), 512'(32'hFFFF_FFE1));

    // Read back through requester 1
    do_load(1, 100, vec);

    // Highest legal base via requester 2
    for (int i = 0; i < 32; i++) vec[i*16 +: 16] = 16'h11E0 + 16'(i);
    do_load(2, 480, vec);

    // Base 481 rejected: one-cycle err with grant, no memory access
    bus.ld_idx[27 +: 9] = 9'd481;
    bus.ld_req = 4'b1000;
    @(negedge clk);
    check("rej_err", 512'(bus.err), 512'(1));
    check("rej_grant", 512'(bus.ld_grant), 512'(4'b1000));
    check("rej_quiet", 512'({bus.busy, bus.mem_we, bus.mem_addr}), 512'(0));
    bus.ld_req = '0;
    @(negedge clk);
    check("rej_pulse_end", 512'({bus.err, bus.ld_grant, bus.busy}), 512'(0));

    // Reset asserted during store lane 10
    for (int i = 0; i < 32; i++) vec[i*16 +: 16] = 16'h0A00 + 16'(i);
    bus.st_idx = 9'd200; bus.st_data = vec; bus.st_req = 1'b1;
    found = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.mem_we === 1'b1 && bus.mem_addr === 9'd210) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_mid_reach_lane10", 512'(found), 512'(1));
    rst_n = 1'b0;
    #1;
    check("rst_mid_we", 512'(bus.mem_we), 512'(0));
    check("rst_mid_outs", 512'({bus.busy, bus.mem_addr, bus.mem_wdata, bus.ld_grant, bus.err}), 512'(0));
    bus.st_req = 1'b0;
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.st_done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (bus.st_done) saw_done = 1'b1;
    check("rst_mid_no_done", 512'(saw_done), 512'(0));
    check("rst_mid_idle", 512'({bus.busy, bus.mem_we}), 512'(0));

    // Contention: store first, then loads 0..3 in round-robin order
    bus.ld_idx  = {9'd400, 9'd64, 9'd32, 9'd0};
    bus.st_idx  = 9'd300;
    bus.st_data = vec;
    bus.ld_req  = 4'b1111;
    bus.st_req  = 1'b1;
    for (int i = 0; i < 5; i++) got[i] = -1;
    n = 0; overlap = 1'b0; err_seen = 1'b0;
    for (int c = 1; c <= 400 && n < 5; c++) begin
      @(negedge clk);
      if ($countones(bus.ld_grant) > 1) overlap = 1'b1;
      if (bus.err) err_seen = 1'b1;
      if (bus.st_done) begin
        if (n < 5) got[n] = 4;
        n++;
        bus.st_req = 1'b0;
      end
      for (int r = 0; r < 4; r++) begin
        if (bus.ld_done[r]) begin
          if (n < 5) got[n] = r;
          n++;
          bus.ld_req[r] = 1'b0;
        end
      end
    end
    check("cont_count", 512'(n), 512'(5));
    check("cont_order0_store", 512'(got[0]), 512'(4));
    check("cont_order1_ld0", 512'(got[1]), 512'(0));
    check("cont_order2_ld1", 512'(got[2]), 512'(1));
    check("cont_order3_ld2", 512'(got[3]), 512'(2));
    check("cont_order4_ld3", 512'(got[4]), 512'(3));
    check("cont_no_overlap", 512'({overlap, err_seen}), 512'(0));
    for (int i = 0; i < 32; i++) vec[i*16 +: 16] = 16'h1190 + 16'(i);
    check("cont_ld3_data", bus.ld_data, vec);
    @(negedge clk);
    check("cont_idle", 512'({bus.busy, bus.ld_grant}), 512'(0));
`ifdef VMEM_PERF_CNT_EN
    check("perf_ld", 512'(perf_ld_cnt), 512'(4));
    check("perf_st", 512'(perf_st_cnt), 512'(1));
    check("perf_wait_nonzero", 512'(perf_wait_cnt > 16'd0), 512'(1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
